// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative shift-add multiplier that stalls the
// front end, combinational forwarding back to ID, and the EX/MEM pipeline register.
//
// state | meaning
// IDLE  | no multiply in flight; a MUL arriving here captures operands and stalls
// BUSY  | retiring MUL_BITS multiplier bits per cycle, front end stalled
// DONE  | product complete; EX/MEM loads the MUL result, front end released
module ex_stage #(
   parameter int MUL_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dm_w_signal_ex,
   input  logic        write_ex,
   input  logic        is_lw_ex,
   input  logic        is_jal_ex,
   input  logic        is_mul_ex,
   input  logic        mux_alu1_ex,
   input  logic [1:0]  mux_alu2_ex,
   input  logic [3:0]  aluc_ex,
   input  logic [31:0] npc_ex,
   input  logic [4:0]  w_addr_ex,
   input  logic [31:0] shamt_ex,
   input  logic [31:0] simmediate_ex,
   input  logic [31:0] uimmediate_ex,
   input  logic [31:0] rs_wire_ex,
   input  logic [31:0] rt_wire_ex,
   input  logic [31:0] dm_wdata_ex,
   output logic        stall_ex,
   output logic        fwd_valid_ex,
   output logic [31:0] fwd_data_ex,
   output logic        write_mem,
   output logic        dm_w_signal_mem,
   output logic        is_lw_mem,
   output logic [4:0]  w_addr_mem,
   output logic [31:0] alu_result_mem,
   output logic [31:0] dm_wdata_mem
);

   localparam int N     = 32 / MUL_BITS;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       op_a;
   logic [31:0]       op_b;
   logic [31:0]       alu;
   logic [31:0]       result;
   logic [31:0]       mcand;
   logic [31:0]       mplier;
   logic [31:0]       acc;
   logic [31:0]       digit;
   logic [CNT_W-1:0]  cnt;

   always_comb begin
      op_a = mux_alu1_ex ? shamt_ex : rs_wire_ex;
      case (mux_alu2_ex)
         2'd0:    op_b = rt_wire_ex;
         2'd1:    op_b = simmediate_ex;
         2'd2:    op_b = uimmediate_ex;
         default: op_b = 32'd0;
      endcase
   end

   always_comb begin
      alu = 32'd0;
      case (aluc_ex)
         4'd0, 4'd12: alu = op_a + op_b;
         4'd1, 4'd13: alu = op_a - op_b;
         4'd2:        alu = op_a & op_b;
         4'd3:        alu = op_a | op_b;
         4'd4:        alu = op_a ^ op_b;
         4'd5:        alu = ~(op_a | op_b);
         4'd6:        alu = {31'd0, $signed(op_a) < $signed(op_b)};
         4'd7:        alu = {31'd0, op_a < op_b};
         4'd8:        alu = op_b << op_a[4:0];
         4'd9:        alu = op_b >> op_a[4:0];
         4'd10:       alu = $signed(op_b) >>> op_a[4:0];
         4'd11:       alu = {op_b[15:0], 16'd0};
         default:     alu = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // DONE always returns to IDLE, so a MUL still present there is not reissued.
   always_comb begin
      state_nxt = state;
      stall_ex  = 1'b0;
      case (state)
         IDLE: begin
            if (is_mul_ex) begin
               stall_ex  = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            stall_ex = 1'b1;
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign digit = {{(32-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= 32'd0;
         mplier <= 32'd0;
         acc    <= 32'd0;
         cnt    <= '0;
      end else if (state == IDLE && is_mul_ex) begin
         mcand  <= rs_wire_ex;
         mplier <= rt_wire_ex;
         acc    <= 32'd0;
         cnt    <= '0;
      end else if (state == BUSY) begin
         acc    <= acc + mcand * digit;
         mcand  <= mcand << MUL_BITS;
         mplier <= mplier >> MUL_BITS;
         cnt    <= cnt + CNT_W'(1);
      end
   end

   // acc only reaches EX/MEM in DONE; earlier MUL cycles are stalled into bubbles.
   assign result       = is_jal_ex ? npc_ex : (is_mul_ex ? acc : alu);
   assign fwd_data_ex  = stall_ex ? 32'd0 : result;
   assign fwd_valid_ex = write_ex & ~is_lw_ex & ~stall_ex & (w_addr_ex != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_mem       <= 1'b0;
         dm_w_signal_mem <= 1'b0;
         is_lw_mem       <= 1'b0;
         w_addr_mem      <= 5'd0;
         alu_result_mem  <= 32'd0;
         dm_wdata_mem    <= 32'd0;
      end else if (stall_ex) begin
         write_mem       <= 1'b0;
         dm_w_signal_mem <= 1'b0;
         is_lw_mem       <= 1'b0;
         w_addr_mem      <= 5'd0;
         alu_result_mem  <= 32'd0;
         dm_wdata_mem    <= 32'd0;
      end else begin
         write_mem       <= write_ex;
         dm_w_signal_mem <= dm_w_signal_ex;
         is_lw_mem       <= is_lw_ex;
         w_addr_mem      <= w_addr_ex;
         alu_result_mem  <= result;
         dm_wdata_mem    <= dm_wdata_ex;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and popped after the clock edge that should load them.
module tb_ex_stage;

   localparam int MUL_BITS   = 2;
   localparam int EXP_STALLS = 32 / MUL_BITS + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        dm_w_signal_ex, write_ex, is_lw_ex, is_jal_ex, is_mul_ex, mux_alu1_ex;
   logic [1:0]  mux_alu2_ex;
   logic [3:0]  aluc_ex;
   logic [31:0] npc_ex;
   logic [4:0]  w_addr_ex;
   logic [31:0] shamt_ex, simmediate_ex, uimmediate_ex, rs_wire_ex, rt_wire_ex, dm_wdata_ex;
   logic        stall_ex, fwd_valid_ex;
   logic [31:0] fwd_data_ex;
   logic        write_mem, dm_w_signal_mem, is_lw_mem;
   logic [4:0]  w_addr_mem;
   logic [31:0] alu_result_mem, dm_wdata_mem;

   ex_stage #(.MUL_BITS(MUL_BITS)) dut (
      .clk(clk), .rst(rst),
      .dm_w_signal_ex(dm_w_signal_ex), .write_ex(write_ex), .is_lw_ex(is_lw_ex),
      .is_jal_ex(is_jal_ex), .is_mul_ex(is_mul_ex), .mux_alu1_ex(mux_alu1_ex),
      .mux_alu2_ex(mux_alu2_ex), .aluc_ex(aluc_ex), .npc_ex(npc_ex), .w_addr_ex(w_addr_ex),
      .shamt_ex(shamt_ex), .simmediate_ex(simmediate_ex), .uimmediate_ex(uimmediate_ex),
      .rs_wire_ex(rs_wire_ex), .rt_wire_ex(rt_wire_ex), .dm_wdata_ex(dm_wdata_ex),
      .stall_ex(stall_ex), .fwd_valid_ex(fwd_valid_ex), .fwd_data_ex(fwd_data_ex),
      .write_mem(write_mem), .dm_w_signal_mem(dm_w_signal_mem), .is_lw_mem(is_lw_mem),
      .w_addr_mem(w_addr_mem), .alu_result_mem(alu_result_mem), .dm_wdata_mem(dm_wdata_mem)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        w;
      logic        dmw;
      logic        lw;
      logic [4:0]  wa;
      logic [31:0] res;
      logic [31:0] wd;
   } mem_t;

   typedef struct {
      logic [3:0]  op;
      logic        m1;
      logic [1:0]  m2;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] sh;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   mem_t sb[$];
   mem_t act, exp_m;
   int   checks = 0;
   int   errors = 0;

   vec_t vecs[16] = '{
      '{4'd0,  1'b0, 2'd0, 32'd5,          32'd7,          32'd0, 32'd0,      32'd12},
      '{4'd1,  1'b0, 2'd0, 32'd5,          32'd7,          32'd0, 32'd0,      32'hFFFF_FFFE},
      '{4'd2,  1'b0, 2'd0, 32'h0000_F0F0,  32'h0000_FF00,  32'd0, 32'd0,      32'h0000_F000},
      '{4'd3,  1'b0, 2'd0, 32'h0000_F0F0,  32'h0000_FF00,  32'd0, 32'd0,      32'h0000_FFF0},
      '{4'd4,  1'b0, 2'd0, 32'h0000_F0F0,  32'h0000_FF00,  32'd0, 32'd0,      32'h0000_0FF0},
      '{4'd5,  1'b0, 2'd0, 32'h0000_F0F0,  32'h0000_FF00,  32'd0, 32'd0,      32'hFFFF_000F},
      '{4'd6,  1'b0, 2'd0, 32'hFFFF_FFFF,  32'd1,          32'd0, 32'd0,      32'd1},
      '{4'd7,  1'b0, 2'd0, 32'hFFFF_FFFF,  32'd1,          32'd0, 32'd0,      32'd0},
      '{4'd8,  1'b1, 2'd0, 32'hFFFF_FFFF,  32'd1,          32'd4, 32'd0,      32'h0000_0010},
      '{4'd9,  1'b1, 2'd0, 32'd0,          32'h8000_0000,  32'd4, 32'd0,      32'h0800_0000},
      '{4'd10, 1'b1, 2'd0, 32'd0,          32'h8000_0000,  32'd4, 32'd0,      32'hF800_0000},
      '{4'd11, 1'b0, 2'd2, 32'd3,          32'd0,          32'd0, 32'h1234,   32'h1234_0000},
      '{4'd12, 1'b0, 2'd0, 32'h7FFF_FFFF,  32'd1,          32'd0, 32'd0,      32'h8000_0000},
      '{4'd13, 1'b0, 2'd0, 32'd0,          32'd1,          32'd0, 32'd0,      32'hFFFF_FFFF},
      '{4'd14, 1'b0, 2'd0, 32'd5,          32'd7,          32'd0, 32'd0,      32'd0},
      '{4'd0,  1'b0, 2'd3, 32'd9,          32'd7,          32'd0, 32'd0,      32'd9}
   };

   function automatic mem_t mem_now();
      return {write_mem, dm_w_signal_mem, is_lw_mem, w_addr_mem, alu_result_mem, dm_wdata_mem};
   endfunction

   task automatic clear_inputs();
      dm_w_signal_ex = 0; write_ex = 0; is_lw_ex = 0; is_jal_ex = 0; is_mul_ex = 0;
      mux_alu1_ex = 0; mux_alu2_ex = 0; aluc_ex = 0; npc_ex = 0; w_addr_ex = 0;
      shamt_ex = 0; simmediate_ex = 0; uimmediate_ex = 0; rs_wire_ex = 0; rt_wire_ex = 0;
      dm_wdata_ex = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      #12;
      checks++;
      if (mem_now() !== '0) begin
         errors++; $display("FAIL reset_mem got %h expected 0", mem_now());
      end
      checks++;
      if (stall_ex !== 1'b0) begin
         errors++; $display("FAIL reset_stall got %b expected 0", stall_ex);
      end
      is_mul_ex = 1'b1; #1;
      checks++;
      if (stall_ex !== 1'b1) begin
         errors++; $display("FAIL reset_stall_mul got %b expected 1", stall_ex);
      end
      is_mul_ex = 1'b0;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_alu();
      for (int i = 0; i < 16; i++) begin
         clear_inputs();
         aluc_ex = vecs[i].op; mux_alu1_ex = vecs[i].m1; mux_alu2_ex = vecs[i].m2;
         rs_wire_ex = vecs[i].rs; rt_wire_ex = vecs[i].rt; shamt_ex = vecs[i].sh;
         simmediate_ex = vecs[i].imm; uimmediate_ex = vecs[i].imm;
         write_ex = 1'b1; w_addr_ex = 5'(i + 1); dm_wdata_ex = 32'(i * 3);
         #1;
         checks++;
         if ({stall_ex, fwd_valid_ex, fwd_data_ex} !== {1'b0, 1'b1, vecs[i].exp}) begin
            errors++;
            $display("FAIL alu_fwd_%0d got stall=%b valid=%b data=%h expected 0 1 %h",
                     i, stall_ex, fwd_valid_ex, fwd_data_ex, vecs[i].exp);
         end
         sb.push_back({1'b1, 1'b0, 1'b0, 5'(i + 1), vecs[i].exp, 32'(i * 3)});
         @(posedge clk); #1;
         exp_m = sb.pop_front(); act = mem_now(); checks++;
         if (act !== exp_m) begin
            errors++; $display("FAIL alu_%0d got %h expected %h", i, act, exp_m);
         end
      end
   endtask

   task automatic test_mem_jal();
      mem_t  e[4];
      logic  fv[4];
      e[0] = {1'b0, 1'b1, 1'b0, 5'd0, 32'h108, 32'hDEAD};
      e[1] = {1'b1, 1'b0, 1'b0, 5'd31, 32'h40, 32'h0};
      e[2] = {1'b1, 1'b0, 1'b1, 5'd4, 32'h204, 32'h0};
      e[3] = {1'b1, 1'b0, 1'b0, 5'd0, 32'd12, 32'h0};
      fv   = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) begin
         clear_inputs();
         case (k)
            0: begin dm_w_signal_ex = 1; mux_alu2_ex = 1; simmediate_ex = 8;
                      rs_wire_ex = 32'h100; dm_wdata_ex = 32'hDEAD; end
            1: begin is_jal_ex = 1; npc_ex = 32'h40; write_ex = 1; w_addr_ex = 31;
                      rs_wire_ex = 5; rt_wire_ex = 7; end
            2: begin is_lw_ex = 1; write_ex = 1; w_addr_ex = 4; mux_alu2_ex = 1;
                      simmediate_ex = 4; rs_wire_ex = 32'h200; end
            default: begin write_ex = 1; w_addr_ex = 0; rs_wire_ex = 5; rt_wire_ex = 7; end
         endcase
         #1;
         checks++;
         if (fwd_valid_ex !== fv[k]) begin
            errors++; $display("FAIL memjal_fwd_%0d got %b expected %b", k, fwd_valid_ex, fv[k]);
         end
         sb.push_back(e[k]);
         @(posedge clk); #1;
         exp_m = sb.pop_front(); act = mem_now(); checks++;
         if (act !== exp_m) begin
            errors++; $display("FAIL memjal_%0d got %h expected %h", k, act, exp_m);
         end
      end
   endtask

   task automatic test_mul();
      int stalls = 0;
      bit done = 0;
      clear_inputs();
      is_mul_ex = 1; write_ex = 1; w_addr_ex = 9; dm_wdata_ex = 32'h55;
      rs_wire_ex = 32'hFFFF_FFFF; rt_wire_ex = 32'd3;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         #1;
         if (stall_ex === 1'b1) begin
            stalls++;
            sb.push_back('0);
         end else begin
            done = 1;
            checks++;
            if ({fwd_valid_ex, fwd_data_ex} !== {1'b1, 32'hFFFF_FFFD}) begin
               errors++;
               $display("FAIL mul_fwd got valid=%b data=%h expected 1 fffffffd", fwd_valid_ex, fwd_data_ex);
            end
            sb.push_back({1'b1, 1'b0, 1'b0, 5'd9, 32'hFFFF_FFFD, 32'h55});
         end
         @(posedge clk); #1;
         if (cyc == 0) begin rs_wire_ex = 32'd0; rt_wire_ex = 32'd0; end
         exp_m = sb.pop_front(); act = mem_now(); checks++;
         if (act !== exp_m) begin
            errors++; $display("FAIL mul_cyc_%0d got %h expected %h", cyc, act, exp_m);
         end
      end
      is_mul_ex = 0;
      checks++;
      if (!done || stalls != EXP_STALLS) begin
         errors++; $display("FAIL mul_stalls got %0d done=%0d expected %0d", stalls, done, EXP_STALLS);
      end
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      write_ex = 1; w_addr_ex = 3; rs_wire_ex = 5; rt_wire_ex = 7;
      #1;
      sb.push_back({1'b1, 1'b0, 1'b0, 5'd3, 32'd12, 32'd0});
      @(posedge clk); #1;
      exp_m = sb.pop_front(); act = mem_now(); checks++;
      if (act !== exp_m) begin
         errors++; $display("FAIL rst_pre got %h expected %h", act, exp_m);
      end
      @(negedge clk) rst = 1'b1;
      #1;
      checks++;
      if (mem_now() !== '0) begin
         errors++; $display("FAIL rst_async got %h expected 0", mem_now());
      end
      @(negedge clk) rst = 1'b0;
      is_mul_ex = 1; w_addr_ex = 10; rs_wire_ex = 6; rt_wire_ex = 7;
      repeat (5) @(posedge clk);
      @(negedge clk);
      is_mul_ex = 0; rst = 1'b1;
      #1;
      checks++;
      if ({stall_ex, mem_now()} !== {1'b0, 72'd0}) begin
         errors++; $display("FAIL rst_mid got stall=%b mem=%h expected 0 0", stall_ex, mem_now());
      end
      @(negedge clk) rst = 1'b0;
      rs_wire_ex = 5; rt_wire_ex = 7; w_addr_ex = 3;
      #1;
      checks++;
      if (stall_ex !== 1'b0) begin
         errors++; $display("FAIL rst_post_stall got %b expected 0", stall_ex);
      end
      sb.push_back({1'b1, 1'b0, 1'b0, 5'd3, 32'd12, 32'd0});
      @(posedge clk); #1;
      exp_m = sb.pop_front(); act = mem_now(); checks++;
      if (act !== exp_m) begin
         errors++; $display("FAIL rst_post got %h expected %h", act, exp_m);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ra[2], rb[2], re[2];
      ra = '{32'd6, 32'h0001_0000};
      rb = '{32'd7, 32'h0001_0000};
      re = '{32'd42, 32'd0};
      clear_inputs();
      write_ex = 1; w_addr_ex = 12; is_mul_ex = 1;
      rs_wire_ex = ra[0]; rt_wire_ex = rb[0];
      for (int k = 0; k < 2; k++) begin
         int stalls = 0;
         bit done = 0;
         for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            #1;
            if (stall_ex === 1'b1) begin
               stalls++;
               sb.push_back('0);
            end else begin
               done = 1;
               sb.push_back({1'b1, 1'b0, 1'b0, 5'd12, re[k], 32'd0});
            end
            @(posedge clk); #1;
            exp_m = sb.pop_front(); act = mem_now(); checks++;
            if (act !== exp_m) begin
               errors++; $display("FAIL b2b_%0d_cyc_%0d got %h expected %h", k, cyc, act, exp_m);
            end
         end
         checks++;
         if (!done || stalls != EXP_STALLS) begin
            errors++; $display("FAIL b2b_%0d_stalls got %0d done=%0d expected %0d", k, stalls, done, EXP_STALLS);
         end
         if (k == 0) begin rs_wire_ex = ra[1]; rt_wire_ex = rb[1]; end
      end
      is_mul_ex = 0;
      #1;
      checks++;
      if (stall_ex !== 1'b0) begin
         errors++; $display("FAIL b2b_idle_stall got %b expected 0", stall_ex);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem_jal();
      test_mul();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
